// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the MEM-stage load/store front-end.
package mem_access_pkg;

  localparam int unsigned NumLanes = 4;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    LD_WAIT,
    LD_RESP
  } state_e;

  // Reserved size never counts as aligned.
  function automatic logic is_aligned(logic [1:0] size, logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~off[0];
      SZ_WORD: return off == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
module load_extract
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [31:0] lane;

  always_comb begin
    lane = rdata >> {offset, 3'b000};
    case (size)
      SZ_BYTE: result = {{24{~is_unsigned & lane[7]}}, lane[7:0]};
      SZ_HALF: result = {{16{~is_unsigned & lane[15]}}, lane[15:0]};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end: alignment check, byte-lane memory drive, and load
// result capture with 2-cycle accept-to-result latency.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned IDXW = 13
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  output logic [IDXW-1:0] mem_idx,
  output logic [3:0]      mem_byte_en,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic            resp_valid,
  output logic [DW-1:0]   resp_rdata,
  output logic            store_done,
  output logic            misalign_err
);

  state_e          state_q;
  logic [IDXW-1:0] idx_q;
  logic [1:0]      off_q;
  logic [1:0]      size_q;
  logic            uns_q;

  logic            accept;
  logic            aligned;
  logic [3:0]      be;
  logic [DW-1:0]   wdata_rep;
  logic [DW-1:0]   ld_result;
  logic            unused_addr;

  // Address range is not checked; bits above the word index are dropped.
  assign unused_addr = ^req_addr[AW-1:IDXW+2];

  assign req_ready = (state_q != LD_WAIT) & ~flush;
  assign accept    = req_valid & req_ready;
  assign aligned   = is_aligned(req_size, req_addr[1:0]);

  always_comb begin
    be        = 4'b1111;
    wdata_rep = req_wdata;
    case (req_size)
      SZ_BYTE: begin
        be        = 4'b0001 << req_addr[1:0];
        wdata_rep = {NumLanes{req_wdata[7:0]}};
      end
      SZ_HALF: begin
        be        = 4'b0011 << req_addr[1:0];
        wdata_rep = {(NumLanes / 2){req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign mem_idx     = accept ? req_addr[IDXW+1:2] : idx_q;
  assign mem_byte_en = (accept & aligned & req_we) ? be : 4'b0000;
  assign mem_wdata   = accept ? wdata_rep : '0;

  load_extract u_load_extract (
    .rdata       (mem_rdata),
    .offset      (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result      (ld_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      off_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      store_done   <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      resp_valid   <= 1'b0;
      store_done   <= 1'b0;
      misalign_err <= 1'b0;
      case (state_q)
        LD_WAIT: begin
          // Flush wins over completion of the outstanding load.
          if (flush) begin
            state_q <= IDLE;
          end else begin
            resp_rdata <= ld_result;
            resp_valid <= 1'b1;
            state_q    <= LD_RESP;
          end
        end
        default: begin
          state_q <= IDLE;
          if (accept) begin
            if (!aligned) begin
              misalign_err <= 1'b1;
            end else if (req_we) begin
              store_done <= 1'b1;
            end else begin
              idx_q   <= req_addr[IDXW+1:2];
              off_q   <= req_addr[1:0];
              size_q  <= req_size;
              uns_q   <= req_unsigned;
              state_q <= LD_WAIT;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, corner sequences and
// randomized traffic against a request-level reference model.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [12:0] mem_idx;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        store_done;
  logic        misalign_err;

  mem_access_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .mem_idx      (mem_idx),
    .mem_byte_en  (mem_byte_en),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .store_done   (store_done),
    .misalign_err (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte-lane data memory with a registered read port.
  logic [31:0] mem [0:8191];
  always @(posedge clk) begin
    mem_rdata <= mem[mem_idx];
    for (int b = 0; b < 4; b++)
      if (mem_byte_en[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
  end

  // Pulse monitor.
  int          n_resp = 0, n_sd = 0, n_me = 0;
  logic [31:0] hist [0:4095];
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid) begin
        hist[n_resp] <= resp_rdata;
        n_resp       <= n_resp + 1;
      end
      if (store_done) n_sd <= n_sd + 1;
      if (misalign_err) n_me <= n_me + 1;
    end
  end

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory image, outstanding load, next-cycle expected pulses.
  logic [31:0] ref_mem [0:8191];
  logic        outstanding = 1'b0;
  logic [31:0] pend_data = '0;
  logic [12:0] pend_idx = '0;
  logic        cur_rv = 1'b0, cur_sd = 1'b0, cur_me = 1'b0;
  logic [31:0] cur_rd = '0;
  logic [3:0]  last_be;
  logic [31:0] last_wd;

  function automatic logic [31:0] ref_load(logic [31:0] w, int off, int nb, logic uns);
    logic [31:0] v;
    if (nb == 4) return w;
    v = (w >> (8 * off)) & ((32'h1 << (8 * nb)) - 32'h1);
    if (!uns && v[8*nb-1]) v = v - (32'h1 << (8 * nb));
    return v;
  endfunction

  task automatic cycle(input logic v, input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd, input logic fl);
    logic        rdy, acc, algn;
    logic        nxt_rv, nxt_sd, nxt_me;
    logic [31:0] nxt_rd, ewd;
    logic [3:0]  ebe;
    int          nb, off;
    @(negedge clk);
    req_valid = v; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = a; req_wdata = wd; flush = fl;
    #1;
    chk("resp_valid", {31'b0, resp_valid}, {31'b0, cur_rv});
    if (cur_rv) chk("resp_rdata", resp_rdata, cur_rd);
    chk("store_done", {31'b0, store_done}, {31'b0, cur_sd});
    chk("misalign_err", {31'b0, misalign_err}, {31'b0, cur_me});
    rdy = !fl && !outstanding;
    chk("req_ready", {31'b0, req_ready}, {31'b0, rdy});
    acc = v && rdy;
    nxt_rv = 1'b0; nxt_sd = 1'b0; nxt_me = 1'b0; nxt_rd = '0;
    if (outstanding) begin
      chk("mem_idx_hold", {19'b0, mem_idx}, {19'b0, pend_idx});
      if (!fl) begin nxt_rv = 1'b1; nxt_rd = pend_data; end
    end
    outstanding = 1'b0;
    if (acc) begin
      off = int'(a[1:0]);
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      algn = (sz != 2'd3) && (off % nb == 0);
      chk("mem_idx", {19'b0, mem_idx}, {19'b0, a[14:2]});
      ebe = '0;
      if (algn && we) for (int i = 0; i < nb; i++) ebe[off+i] = 1'b1;
      chk("mem_byte_en", {28'b0, mem_byte_en}, {28'b0, ebe});
      last_be = mem_byte_en;
      last_wd = mem_wdata;
      if (algn && we) begin
        for (int l = 0; l < 4; l++) ewd[8*l +: 8] = wd[8*(l % nb) +: 8];
        chk("mem_wdata", mem_wdata, ewd);
        for (int i = 0; i < nb; i++) ref_mem[a[14:2]][8*(off+i) +: 8] = wd[8*i +: 8];
        nxt_sd = 1'b1;
      end else if (algn) begin
        outstanding = 1'b1;
        pend_idx    = a[14:2];
        pend_data   = ref_load(ref_mem[a[14:2]], off, nb, uns);
      end else begin
        nxt_me = 1'b1;
      end
    end else begin
      chk("mem_byte_en_idle", {28'b0, mem_byte_en}, 32'h0);
    end
    cur_rv = nxt_rv; cur_rd = nxt_rd; cur_sd = nxt_sd; cur_me = nxt_me;
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = 1'b0; flush = 1'b0;
    #1;
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_store_done", {31'b0, store_done}, 32'h0);
    chk("rst_misalign_err", {31'b0, misalign_err}, 32'h0);
    chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
    outstanding = 1'b0; cur_rv = 1'b0; cur_sd = 1'b0; cur_me = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [31:0] ewd;
    int          kind;  // 0 store, 1 load, 2 misaligned
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [16];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, s0, m0;
    tbl[0]  = '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 0, 32'h0};
    tbl[1]  = '{1'b1, 2'd0, 1'b0, 32'h13, 32'h000000A5, 4'h8, 32'hA5A5A5A5, 0, 32'h0};
    tbl[2]  = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1, 32'hA5ADBEEF};
    tbl[3]  = '{1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 4'h0, 32'h0, 1, 32'hFFFFFFAD};
    tbl[4]  = '{1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 4'h0, 32'h0, 1, 32'h000000AD};
    tbl[5]  = '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1, 32'hFFFFBEEF};
    tbl[6]  = '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0, 4'h0, 32'h0, 1, 32'h0000A5AD};
    tbl[7]  = '{1'b0, 2'd2, 1'b0, 32'h11, 32'h0, 4'h0, 32'h0, 2, 32'h0};
    tbl[8]  = '{1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 2, 32'h0};
    tbl[9]  = '{1'b1, 2'd3, 1'b0, 32'h10, 32'h12345678, 4'h0, 32'h0, 2, 32'h0};
    tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1, 32'hA5ADBEEF};
    tbl[11] = '{1'b1, 2'd2, 1'b0, 32'h14, 32'h00000000, 4'hF, 32'h00000000, 0, 32'h0};
    tbl[12] = '{1'b1, 2'd1, 1'b0, 32'h16, 32'h12345678, 4'hC, 32'h56785678, 0, 32'h0};
    tbl[13] = '{1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 4'h0, 32'h0, 1, 32'h56780000};
    tbl[14] = '{1'b0, 2'd2, 1'b0, 32'hFFFF0010, 32'h0, 4'h0, 32'h0, 1, 32'hA5ADBEEF};
    tbl[15] = '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1, 32'hFFFFFFA5};

    rst_n = 1'b0; flush = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    do_reset();

    // Directed table.
    for (int t = 0; t < 16; t++) begin
      n0 = n_resp; s0 = n_sd; m0 = n_me;
      cycle(1'b1, tbl[t].we, tbl[t].sz, tbl[t].uns, tbl[t].addr, tbl[t].wd, 1'b0);
      chk($sformatf("tbl%0d_be", t), {28'b0, last_be}, {28'b0, tbl[t].be});
      if (tbl[t].kind == 0) chk($sformatf("tbl%0d_wdata", t), last_wd, tbl[t].ewd);
      idle(3);
      chk($sformatf("tbl%0d_resp_cnt", t), n_resp - n0, (tbl[t].kind == 1) ? 1 : 0);
      chk($sformatf("tbl%0d_sd_cnt", t), n_sd - s0, (tbl[t].kind == 0) ? 1 : 0);
      chk($sformatf("tbl%0d_me_cnt", t), n_me - m0, (tbl[t].kind == 2) ? 1 : 0);
      if (tbl[t].kind == 1) chk($sformatf("tbl%0d_rdata", t), hist[n0], tbl[t].rd);
    end

    // Back-to-back loads with req_valid held.
    n0 = n_resp;
    cycle(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b0);
    idle(3);
    chk("b2b_cnt", n_resp - n0, 2);
    chk("b2b_first", hist[n0], 32'hA5ADBEEF);
    chk("b2b_second", hist[n0+1], 32'h56780000);

    // Flush during LD_WAIT drops the load; next request accepted right after.
    n0 = n_resp;
    cycle(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    cycle(1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b1);
    cycle(1'b1, 1'b0, 2'd2, 1'b0, 32'h14, 32'h0, 1'b0);
    idle(3);
    chk("flush_cnt", n_resp - n0, 1);
    chk("flush_data", hist[n0], 32'h56780000);

    // Reset during LD_WAIT abandons the load.
    n0 = n_resp;
    cycle(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0);
    do_reset();
    idle(3);
    chk("rst_ldwait_cnt", n_resp - n0, 0);

    // Randomized traffic over a small word window.
    for (int w = 0; w < 16; w++) cycle(1'b1, 1'b1, 2'd2, 1'b0, w * 4, $urandom, 1'b0);
    for (int i = 0; i < 600; i++) begin
      logic [31:0] a;
      a = ($urandom & 32'hFFFF8000) | 32'($urandom_range(0, 63));
      cycle($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 9) == 0);
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
